bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 15 +
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  localparam logic [3:0]  CODE_X     = 4'hA;
  localparam logic [3:0]  CODE_Y     = 4'hB;
  localparam logic [3:0]  CODE_BLANK = 4'hF;
  localparam int unsigned MAX_DEC    = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  // A digit >= 5 would become >= 10 after doubling; pre-add 3 so the carry lands in the next digit.
  always_comb begin
    nibble_o = nibble_i;
    if (nibble_i >= 4'd5) begin
      nibble_o = nibble_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter for a 4-digit display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 never blanked).
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W = 14
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_value,
  output logic            out_valid,
  output logic            busy,
  output logic            overflow,
  output logic [3:0]      digit3,
  output logic [3:0]      digit2,
  output logic [3:0]      digit1,
  output logic [3:0]      digit0
);

  localparam int unsigned CntW = $clog2(IN_W + 1);

  bcd_state_e      state_q, state_d;
  logic [IN_W-1:0] bin_q;
  logic [15:0]     bcd_q;
  logic [CntW-1:0] cnt_q;
  logic            ovf_pend_q;
  logic [15:0]     dig_q;
  logic            ovf_q;

  logic            handshake;
  logic            last_shift;
  logic [15:0]     bcd_corr;
  logic [15+IN_W:0] shift_w;
  logic [15:0]     bcd_shifted;
  logic [IN_W-1:0] bin_shifted;
  logic [15:0]     dig_fmt;

  assign handshake  = in_valid && in_ready;
  assign last_shift = (state_q == StShift) && (cnt_q == CntW'(1));

  // Four parallel nibble corrections ahead of the shift.
  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble_i (bcd_q[4*g +: 4]),
      .nibble_o (bcd_corr[4*g +: 4])
    );
  end

  assign shift_w     = {bcd_corr, bin_q} << 1;
  assign bcd_shifted = shift_w[15+IN_W:IN_W];
  assign bin_shifted = shift_w[IN_W-1:0];

  // Final digit codes: all-X on overflow, optional leading-zero blanking otherwise.
  always_comb begin
    dig_fmt = bcd_shifted;
    if (ovf_pend_q) begin
      dig_fmt = {CODE_X, CODE_X, CODE_X, CODE_X};
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_shifted[15:12] == 4'd0) begin
        dig_fmt[15:12] = CODE_BLANK;
        if (bcd_shifted[11:8] == 4'd0) begin
          dig_fmt[11:8] = CODE_BLANK;
          if (bcd_shifted[7:4] == 4'd0) begin
            dig_fmt[7:4] = CODE_BLANK;
          end
        end
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (handshake) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake-facing outputs; all forced low while RESET is high.
  always_comb begin
    in_ready  = (state_q == StIdle) && !RESET;
    busy      = (state_q != StIdle) && !RESET;
    out_valid = (state_q == StDone) && !RESET;
  end

  // Datapath: latch on handshake, shift while converting, capture results entering DONE so
  // they are already stable while out_valid is high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (handshake) begin
      bin_q      <= in_value;
      bcd_q      <= '0;
      cnt_q      <= CntW'(IN_W);
      ovf_pend_q <= 32'(in_value) > MAX_DEC;
    end else if (state_q == StShift) begin
      bin_q <= bin_shifted;
      bcd_q <= bcd_shifted;
      cnt_q <= cnt_q - CntW'(1);
      if (last_shift) begin
        dig_q <= dig_fmt;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign digit3   = dig_q[15:12];
  assign digit2   = dig_q[11:8];
  assign digit1   = dig_q[7:4];
  assign digit0   = dig_q[3:0];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes model results, monitor checks on out_valid.
module tb_bin2bcd_seq;

  localparam int unsigned IN_W = 14;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_value = '0;
  logic            out_valid;
  logic            busy;
  logic            overflow;
  logic [3:0]      digit3, digit2, digit1, digit0;

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .busy      (busy),
    .overflow  (overflow),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] exp;
    int          h;
    int unsigned v;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [16:0] last_out = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: decimal digits by plain division, overflow -> all X.
  function automatic logic [16:0] model(input int unsigned v);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return {1'b1, 16'hAAAA};
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (d3 == 0) begin
      d3 = 4'hF;
      if (d2 == 0) begin
        d2 = 4'hF;
        if (d1 == 0) d1 = 4'hF;
      end
    end
`endif
    return {1'b0, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset behaviour, result/latency on out_valid, hold between pulses.
  always @(negedge CLK) begin
    logic [16:0] act;
    act = {overflow, digit3, digit2, digit1, digit0};
    if (RESET) begin
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_in_ready", int'(in_ready), 0);
      sb.delete();
      last_out = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("result_%0d", e.v), int'(act), int'(e.exp));
        chk($sformatf("latency_%0d", e.v), cyc - e.h, int'(IN_W) + 1);
        chk("busy_in_done", int'(busy), 1);
        chk("in_ready_in_done", int'(in_ready), 0);
        last_out = e.exp;
      end
    end else begin
      chk("hold_outputs", int'(act), int'(last_out));
    end
  end

  // Offer v until accepted; h is the handshake cycle. Called just after a rising edge.
  task automatic send(input int unsigned v, input bit hold, output int h);
    bit ok;
    sb_t e;
    ok = 1'b0;
    h = -1;
    in_valid = 1'b1;
    in_value = IN_W'(v);
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      h = cyc;
      e.exp = model(v);
      e.h = h;
      e.v = v;
      sb.push_back(e);
      chk("busy_at_handshake", int'(busy), 0);
    end
    @(posedge CLK);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge CLK);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int h1, h2;
    int unsigned dir_vals[10];
    dir_vals = '{1234, 9999, 10000, 0, 7, 9998, 10001, 16383, 1000, 10};

    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_reset", int'(in_ready), 1);
    chk("digits_after_reset", int'({overflow, digit3, digit2, digit1, digit0}), 0);
    @(posedge CLK);
    #1;

    foreach (dir_vals[i]) send(dir_vals[i], 1'b0, h1);
    drain();

    // Value changes under in_valid while busy must not be sampled.
    send(42, 1'b1, h1);
    send(5555, 1'b0, h2);
    chk("accept_after_out_valid", h2 - h1, int'(IN_W) + 2);
    drain();

    // Abort at the fifth SHIFT cycle.
    send(1234, 1'b0, h1);
    drain();
    send(4321, 1'b0, h1);
    repeat (4) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_abort", int'(in_ready), 1);
    chk("busy_after_abort", int'(busy), 0);
    repeat (20) @(posedge CLK);
    #1;
    send(8765, 1'b0, h1);
    drain();

    // Back-to-back with in_valid held high.
    send(1111, 1'b1, h1);
    send(2222, 1'b0, h2);
    chk("back_to_back_spacing", h2 - h1, int'(IN_W) + 2);
    drain();

    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, (1 << IN_W) - 1), $urandom_range(0, 1) == 1, h1);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge CLK);
        #1;
      end
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
